// File: rtl/serial_chunk_adder.sv
// Multi-cycle add/subtract unit: adds CHUNK bits per clock over WIDTH/CHUNK cycles,
// with carry-in, subtract mode, carry/overflow/zero flags and valid/ready handshakes.
//
// state | meaning
// IDLE  | ready for a new operation, result registers hold the last completion
// RUN   | adding one chunk per cycle, LSB chunk first
// DONE  | result and flags valid, waiting for out_ready
module serial_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("serial_chunk_adder: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_nxt;
  logic             c_q;
  logic [IW-1:0]    idx_q;
  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic             msb_cin;
  logic             last;
  logic             accept;

  always_comb begin
    a_chunk   = a_q[int'(idx_q)*CHUNK +: CHUNK];
    b_chunk   = b_q[int'(idx_q)*CHUNK +: CHUNK];
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, c_q};
    // carry into the chunk's top bit recovered from its sum bit
    msb_cin   = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];
    acc_nxt   = acc_q;
    acc_nxt[int'(idx_q)*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
    last      = (idx_q == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = rst_n;
        accept   = in_valid && rst_n;
        if (accept) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      c_q   <= 1'b0;
      idx_q <= '0;
      out   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else if (accept) begin
      a_q   <= in1;
      b_q   <= sub ? ~in2 : in2;
      c_q   <= sub | cin;
      idx_q <= '0;
      acc_q <= '0;
    end else if (state == RUN) begin
      acc_q <= acc_nxt;
      c_q   <= chunk_sum[CHUNK];
      idx_q <= idx_q + 1'b1;
      if (last) begin
        out  <= acc_nxt;
        cout <= chunk_sum[CHUNK];
        ovf  <= msb_cin ^ chunk_sum[CHUNK];
        zero <= (acc_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Directed bench for serial_chunk_adder: 16/4, 32/8 and 8/8 instances sharing clk and rst_n.
module tb_serial_chunk_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic        iv16, ir16, ov16, or16, ci16, sb16, co16, of16, z16;
  logic [15:0] a16, b16, r16;
  logic        iv32, ir32, ov32, or32, ci32, sb32, co32, of32, z32;
  logic [31:0] a32, b32, r32;
  logic        iv8, ir8, ov8, or8, ci8, sb8, co8, of8, z8;
  logic [7:0]  a8, b8, r8;

  serial_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .in1(a16), .in2(b16),
    .cin(ci16), .sub(sb16), .out_valid(ov16), .out_ready(or16), .out(r16),
    .cout(co16), .ovf(of16), .zero(z16));

  serial_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .in1(a32), .in2(b32),
    .cin(ci32), .sub(sb32), .out_valid(ov32), .out_ready(or32), .out(r32),
    .cout(co32), .ovf(of32), .zero(z32));

  serial_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in1(a8), .in2(b8),
    .cin(ci8), .sub(sb8), .out_valid(ov8), .out_ready(or8), .out(r8),
    .cout(co8), .ovf(of8), .zero(z8));

  function automatic logic cur_valid(int sel);
    case (sel)
      32:      return ov32;
      8:       return ov8;
      default: return ov16;
    endcase
  endfunction

  function automatic logic cur_ready(int sel);
    case (sel)
      32:      return ir32;
      8:       return ir8;
      default: return ir16;
    endcase
  endfunction

  task automatic drive(int sel, logic v, logic [31:0] a, logic [31:0] b, logic ci, logic sb);
    case (sel)
      32: begin iv32 = v; a32 = a; b32 = b; ci32 = ci; sb32 = sb; end
      8:  begin iv8 = v; a8 = a[7:0]; b8 = b[7:0]; ci8 = ci; sb8 = sb; end
      default: begin iv16 = v; a16 = a[15:0]; b16 = b[15:0]; ci16 = ci; sb16 = sb; end
    endcase
  endtask

  // Issues one operation, returns result/flags and cycles from handshake edge to out_valid.
  // The unit is left in DONE; the caller releases it.
  task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                        input logic ci, input logic sb, output logic [31:0] r,
                        output logic co, output logic of, output logic z, output int lat);
    int w = 0;
    @(negedge clk);
    while (!cur_ready(sel) && w < 20) begin @(negedge clk); w++; end
    if (w >= 20) begin
      n_cmp++; n_err++;
      $display("FAIL ready_timeout dut%0d: in_ready never rose, required 1", sel);
    end
    drive(sel, 1'b1, a, b, ci, sb);
    @(posedge clk);
    @(negedge clk);
    drive(sel, 1'b0, 32'hDEAD_BEEF, 32'h0BAD_F00D, ~ci, ~sb);
    lat = 0;
    while (!cur_valid(sel) && lat < 20) begin @(posedge clk); lat++; @(negedge clk); end
    case (sel)
      32:      begin r = r32; co = co32; of = of32; z = z32; end
      8:       begin r = {24'h0, r8}; co = co8; of = of8; z = z8; end
      default: begin r = {16'h0, r16}; co = co16; of = of16; z = z16; end
    endcase
  endtask

  task automatic release_out(int sel);
    case (sel)
      32: or32 = 1'b1;
      8:  or8 = 1'b1;
      default: or16 = 1'b1;
    endcase
    @(posedge clk);
    @(negedge clk);
    or16 = 1'b0; or32 = 1'b0; or8 = 1'b0;
  endtask

  logic [31:0] r;
  logic        co, of, z;
  int          lat;

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({r16, co16, of16, z16, ov16, ir16} !== 22'h0) begin
      n_err++;
      $display("FAIL reset16: got out=%h c=%b v=%b z=%b ov=%b ir=%b, required all 0",
               r16, co16, of16, z16, ov16, ir16);
    end
    n_cmp++;
    if ({r32, ov32, ir32, r8, ov8, ir8} !== 46'h0) begin
      n_err++;
      $display("FAIL reset_others: got out32=%h ov=%b ir=%b out8=%h ov=%b ir=%b, required all 0",
               r32, ov32, ir32, r8, ov8, ir8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ir16 !== 1'b1 || ov16 !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: got ir=%b ov=%b, required ir=1 ov=0", ir16, ov16);
    end
  endtask

  task automatic test_basic_add();
    run_op(16, 32'h1234, 32'h0FCD, 1'b0, 1'b0, r, co, of, z, lat);
    n_cmp++;
    if ({r[15:0], co, of, z} !== {16'h2201, 3'b000} || lat !== 4) begin
      n_err++;
      $display("FAIL add_1234_0fcd: got out=%h c=%b v=%b z=%b lat=%0d, required 2201 0 0 0 lat=4",
               r[15:0], co, of, z, lat);
    end
    release_out(16);
  endtask

  task automatic test_carry_ripple();
    run_op(16, 32'hFFFF, 32'h0001, 1'b0, 1'b0, r, co, of, z, lat);
    n_cmp++;
    if ({r[15:0], co, of, z} !== {16'h0000, 3'b101} || lat !== 4) begin
      n_err++;
      $display("FAIL add_ffff_0001: got out=%h c=%b v=%b z=%b lat=%0d, required 0000 1 0 1 lat=4",
               r[15:0], co, of, z, lat);
    end
    release_out(16);
    run_op(16, 32'h0001, 32'h0001, 1'b1, 1'b0, r, co, of, z, lat);
    n_cmp++;
    if ({r[15:0], co, of, z} !== {16'h0003, 3'b000}) begin
      n_err++;
      $display("FAIL add_cin_no_stale: got out=%h c=%b v=%b z=%b, required 0003 0 0 0",
               r[15:0], co, of, z);
    end
    release_out(16);
  endtask

  task automatic test_overflow_sub();
    run_op(16, 32'h7FFF, 32'h0001, 1'b0, 1'b0, r, co, of, z, lat);
    n_cmp++;
    if ({r[15:0], co, of, z} !== {16'h8000, 3'b010}) begin
      n_err++;
      $display("FAIL add_ovf: got out=%h c=%b v=%b z=%b, required 8000 0 1 0", r[15:0], co, of, z);
    end
    release_out(16);
    // cin=1 must be ignored in subtract mode
    run_op(16, 32'h8000, 32'h0001, 1'b1, 1'b1, r, co, of, z, lat);
    n_cmp++;
    if ({r[15:0], co, of, z} !== {16'h7FFF, 3'b110}) begin
      n_err++;
      $display("FAIL sub_ovf: got out=%h c=%b v=%b z=%b, required 7fff 1 1 0", r[15:0], co, of, z);
    end
    release_out(16);
    run_op(16, 32'h0005, 32'h0007, 1'b0, 1'b1, r, co, of, z, lat);
    n_cmp++;
    if ({r[15:0], co, of, z} !== {16'hFFFE, 3'b000} || lat !== 4) begin
      n_err++;
      $display("FAIL sub_borrow: got out=%h c=%b v=%b z=%b lat=%0d, required fffe 0 0 0 lat=4",
               r[15:0], co, of, z, lat);
    end
    release_out(16);
  endtask

  task automatic test_backpressure();
    int bad = 0;
    run_op(16, 32'h1234, 32'h0FCD, 1'b0, 1'b0, r, co, of, z, lat);
    for (int i = 0; i < 10; i++) begin
      drive(16, 1'b1, 32'h1111 * i, 32'h2222, 1'b1, i[0]);
      @(posedge clk);
      @(negedge clk);
      if (ov16 !== 1'b1 || ir16 !== 1'b0 || r16 !== 16'h2201 || {co16, of16, z16} !== 3'b000) bad++;
    end
    drive(16, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    n_cmp++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL backpressure_hold: got %0d bad cycles (last ov=%b ir=%b out=%h), required 0",
               bad, ov16, ir16, r16);
    end
    release_out(16);
    n_cmp++;
    if (ov16 !== 1'b0 || ir16 !== 1'b1 || r16 !== 16'h2201) begin
      n_err++;
      $display("FAIL backpressure_release: got ov=%b ir=%b out=%h, required ov=0 ir=1 out=2201",
               ov16, ir16, r16);
    end
    repeat (6) @(negedge clk);
    n_cmp++;
    if (ov16 !== 1'b0 || ir16 !== 1'b1) begin
      n_err++;
      $display("FAIL backpressure_no_accept: got ov=%b ir=%b, required ov=0 ir=1", ov16, ir16);
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    drive(16, 1'b1, 32'h1234, 32'h1111, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(16, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({r16, co16, of16, z16, ov16, ir16} !== 22'h0) begin
      n_err++;
      $display("FAIL reset_mid_run: got out=%h c=%b v=%b z=%b ov=%b ir=%b, required all 0",
               r16, co16, of16, z16, ov16, ir16);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (ov16 !== 1'b0 || ir16 !== 1'b1) begin
      n_err++;
      $display("FAIL reset_discard: got ov=%b ir=%b, required ov=0 ir=1", ov16, ir16);
    end
    run_op(16, 32'h00FF, 32'h0001, 1'b0, 1'b0, r, co, of, z, lat);
    n_cmp++;
    if ({r[15:0], co, of, z} !== {16'h0100, 3'b000} || lat !== 4) begin
      n_err++;
      $display("FAIL after_reset_add: got out=%h c=%b v=%b z=%b lat=%0d, required 0100 0 0 0 lat=4",
               r[15:0], co, of, z, lat);
    end
    release_out(16);
  endtask

  task automatic test_param_sweep();
    run_op(32, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, r, co, of, z, lat);
    n_cmp++;
    if ({r, co, of, z} !== {32'h0, 3'b101} || lat !== 4) begin
      n_err++;
      $display("FAIL w32_c8: got out=%h c=%b v=%b z=%b lat=%0d, required 00000000 1 0 1 lat=4",
               r, co, of, z, lat);
    end
    release_out(32);
    run_op(8, 32'h7F, 32'h01, 1'b0, 1'b0, r, co, of, z, lat);
    n_cmp++;
    if ({r[7:0], co, of, z} !== {8'h80, 3'b010} || lat !== 1) begin
      n_err++;
      $display("FAIL w8_c8: got out=%h c=%b v=%b z=%b lat=%0d, required 80 0 1 0 lat=1",
               r[7:0], co, of, z, lat);
    end
    release_out(8);
    n_cmp++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0) begin
      n_err++;
      $display("FAIL w8_release: got ir=%b ov=%b, required ir=1 ov=0", ir8, ov8);
    end
  endtask

  initial begin
    drive(16, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    drive(32, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    drive(8, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    or16 = 1'b0; or32 = 1'b0; or8 = 1'b0;
    test_reset();
    test_basic_add();
    test_carry_ripple();
    test_overflow_sub();
    test_backpressure();
    test_reset_mid_run();
    test_param_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
